instruction_fetch: RTL and testbench

Fetch stage directly upstream of the instruction memory: owns the program counter, drives the memory read address, and captures the returned instruction word into an IF/ID output register for the decoder. Handles sequential PC+4 advance, branch/jump redirect with flush, downstream stall, and halt. The instruction memory is purely combinational, so the read data for pc_o is valid in the same cycle.

---
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: instruction memory read port, pipeline control inputs and the IF/ID outputs.
interface instruction_fetch_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
);
  logic [INS_ADDRESS-1:0] pc_o;
  logic [INS_W-1:0]       imem_rd_i;
  logic                   stall_i;
  logic                   redirect_i;
  logic [INS_ADDRESS-1:0] redirect_pc_i;
  logic                   halt_i;
  logic                   if_valid_o;
  logic [INS_W-1:0]       if_instr_o;
  logic [INS_ADDRESS-1:0] if_pc_o;
  logic [INS_ADDRESS-1:0] if_pc_plus4_o;
  logic                   misalign_o;
  logic [15:0]            fetch_cnt_o;
  logic [1:0]             state_o;

  modport master (
    output pc_o, if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o,
           misalign_o, fetch_cnt_o, state_o,
    input  imem_rd_i, stall_i, redirect_i, redirect_pc_i, halt_i
  );

  modport slave (
    input  pc_o, if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o,
           misalign_o, fetch_cnt_o, state_o,
    output imem_rd_i, stall_i, redirect_i, redirect_pc_i, halt_i
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// registers the returned word into the IF/ID register.
module instruction_fetch #(
  parameter int                   INS_ADDRESS = 9,
  parameter int                   INS_W       = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC  = '0
) (
  input logic           clk,
  input logic           rst_n,
  instruction_fetch_if.master bus
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [INS_ADDRESS-1:0] FOUR = INS_ADDRESS'(4);

  logic [1:0]             state;
  logic [INS_ADDRESS-1:0] pc_p0;
  logic                   vld_p1;
  logic [INS_W-1:0]       instr_p1;
  logic [INS_ADDRESS-1:0] pc_p1;
  logic [INS_ADDRESS-1:0] pc_plus4_p1;
  logic                   misalign_p1;
  logic [15:0]            fetch_cnt;
  logic [INS_ADDRESS-1:0] target;

  // Wraps modulo 2^INS_ADDRESS by truncation to the PC width.
  function automatic logic [INS_ADDRESS-1:0] pc_add4(input logic [INS_ADDRESS-1:0] pc);
    return pc + FOUR;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Misaligned targets are accepted with the low two bits dropped.
  assign target = {bus.redirect_pc_i[INS_ADDRESS-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_p0       <= RESET_PC;
      vld_p1      <= 1'b0;
      instr_p1    <= '0;
      pc_p1       <= '0;
      pc_plus4_p1 <= FOUR;
      misalign_p1 <= 1'b0;
      fetch_cnt   <= 16'd0;
    end else begin
      misalign_p1 <= 1'b0;
      case (state)
        BOOT: begin
          vld_p1 <= 1'b0;
          state  <= RUN;
          if (bus.redirect_i) begin
            pc_p0       <= target;
            misalign_p1 <= |bus.redirect_pc_i[1:0];
          end
        end
        RUN: begin
          if (bus.redirect_i) begin
            pc_p0       <= target;
            vld_p1      <= 1'b0;
            misalign_p1 <= |bus.redirect_pc_i[1:0];
          end else if (bus.stall_i) begin
            // Hold everything; halt is deferred until the stall clears.
          end else if (bus.halt_i) begin
            vld_p1 <= 1'b0;
            state  <= HALT;
          end else begin
            // IF/ID capture boundary
            instr_p1    <= bus.imem_rd_i;
            pc_p1       <= pc_p0;
            pc_plus4_p1 <= pc_add4(pc_p0);
            vld_p1      <= 1'b1;
            pc_p0       <= pc_add4(pc_p0);
            fetch_cnt   <= sat_inc16(fetch_cnt);
          end
        end
        HALT: begin
          vld_p1 <= 1'b0;
          if (bus.redirect_i) begin
            pc_p0       <= target;
            misalign_p1 <= |bus.redirect_pc_i[1:0];
            state       <= RUN;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= BOOT;
        end
      endcase
    end
  end

  assign bus.pc_o          = pc_p0;
  assign bus.if_valid_o    = vld_p1;
  assign bus.if_instr_o    = instr_p1;
  assign bus.if_pc_o       = pc_p1;
  assign bus.if_pc_plus4_o = pc_plus4_p1;
  assign bus.misalign_o    = misalign_p1;
  assign bus.fetch_cnt_o   = fetch_cnt;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small combinational instruction memory.
module tb_instruction_fetch;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [31:0] mem [0:127];

  instruction_fetch_if #(.INS_ADDRESS(9), .INS_W(32)) bus ();

  instruction_fetch #(.INS_ADDRESS(9), .INS_W(32), .RESET_PC(9'h000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_rd_i = mem[bus.pc_o[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cap(input string tag, input logic [31:0] instr, input logic [8:0] pc,
                         input logic [8:0] pc4, input logic [15:0] cnt, input logic [8:0] next_pc);
    chk({tag, ".valid"}, 32'(bus.if_valid_o), 32'd1);
    chk({tag, ".instr"}, bus.if_instr_o, instr);
    chk({tag, ".if_pc"}, 32'(bus.if_pc_o), 32'(pc));
    chk({tag, ".plus4"}, 32'(bus.if_pc_plus4_o), 32'(pc4));
    chk({tag, ".cnt"}, 32'(bus.fetch_cnt_o), 32'(cnt));
    chk({tag, ".pc"}, 32'(bus.pc_o), 32'(next_pc));
    chk({tag, ".mis"}, 32'(bus.misalign_o), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
    mem[0]   = 32'h0000_7033;
    mem[1]   = 32'h0010_0093;
    mem[2]   = 32'h0020_0113;
    mem[3]   = 32'h0020_8433;
    mem[127] = 32'hDEAD_BEEF;

    rst_n             = 1'b0;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 9'h000;
    bus.halt_i        = 1'b0;
    step();
    step();
    chk("rst.pc", 32'(bus.pc_o), 32'h000);
    chk("rst.valid", 32'(bus.if_valid_o), 32'd0);
    chk("rst.instr", bus.if_instr_o, 32'h0);
    chk("rst.if_pc", 32'(bus.if_pc_o), 32'h0);
    chk("rst.plus4", 32'(bus.if_pc_plus4_o), 32'h4);
    chk("rst.mis", 32'(bus.misalign_o), 32'd0);
    chk("rst.cnt", 32'(bus.fetch_cnt_o), 32'd0);
    chk("rst.state", 32'(bus.state_o), 32'd0);

    rst_n = 1'b1;
    step();
    chk("boot.state", 32'(bus.state_o), 32'd1);
    chk("boot.valid", 32'(bus.if_valid_o), 32'd0);
    chk("boot.pc", 32'(bus.pc_o), 32'h000);

    step();
    chk_cap("seq0", 32'h0000_7033, 9'h000, 9'h004, 16'd1, 9'h004);
    step();
    chk_cap("seq1", 32'h0010_0093, 9'h004, 9'h008, 16'd2, 9'h008);

    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_cap("stall", 32'h0010_0093, 9'h004, 9'h008, 16'd2, 9'h008);
    end
    bus.stall_i = 1'b0;
    step();
    chk_cap("seq2", 32'h0020_0113, 9'h008, 9'h00C, 16'd3, 9'h00C);

    // Redirect wins over a simultaneous stall; misaligned target rounds down.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 9'h00E;
    bus.stall_i       = 1'b1;
    step();
    chk("redir.pc", 32'(bus.pc_o), 32'h00C);
    chk("redir.valid", 32'(bus.if_valid_o), 32'd0);
    chk("redir.mis", 32'(bus.misalign_o), 32'd1);
    chk("redir.cnt", 32'(bus.fetch_cnt_o), 32'd3);
    bus.redirect_i = 1'b0;
    bus.stall_i    = 1'b0;
    step();
    chk_cap("seq3", 32'h0020_8433, 9'h00C, 9'h010, 16'd4, 9'h010);

    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 9'h1FC;
    step();
    chk("wrap.redir_pc", 32'(bus.pc_o), 32'h1FC);
    chk("wrap.redir_mis", 32'(bus.misalign_o), 32'd0);
    chk("wrap.redir_valid", 32'(bus.if_valid_o), 32'd0);
    bus.redirect_i = 1'b0;
    step();
    chk_cap("wrap", 32'hDEAD_BEEF, 9'h1FC, 9'h000, 16'd5, 9'h000);

    bus.halt_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) bus.halt_i = 1'b0;
      if (i == 6) bus.stall_i = 1'b1;
      chk("halt.state", 32'(bus.state_o), 32'd2);
      chk("halt.valid", 32'(bus.if_valid_o), 32'd0);
      chk("halt.pc", 32'(bus.pc_o), 32'h000);
      chk("halt.cnt", 32'(bus.fetch_cnt_o), 32'd5);
    end
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 9'h004;
    step();
    chk("resume.state", 32'(bus.state_o), 32'd1);
    chk("resume.pc", 32'(bus.pc_o), 32'h004);
    chk("resume.valid", 32'(bus.if_valid_o), 32'd0);
    bus.redirect_i = 1'b0;
    step();
    chk_cap("resume", 32'h0010_0093, 9'h004, 9'h008, 16'd6, 9'h008);

    // Reset during a stall, with a redirect pending, still takes priority.
    bus.stall_i = 1'b1;
    step();
    chk("pre_rst.valid", 32'(bus.if_valid_o), 32'd1);
    rst_n             = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 9'h040;
    step();
    chk("mid_rst.valid", 32'(bus.if_valid_o), 32'd0);
    chk("mid_rst.pc", 32'(bus.pc_o), 32'h000);
    chk("mid_rst.cnt", 32'(bus.fetch_cnt_o), 32'd0);
    chk("mid_rst.state", 32'(bus.state_o), 32'd0);
    chk("mid_rst.instr", bus.if_instr_o, 32'h0);
    chk("mid_rst.plus4", 32'(bus.if_pc_plus4_o), 32'h4);
    chk("mid_rst.mis", 32'(bus.misalign_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
